// File: rtl/format_decode_stage_if.sv
// format_decode_stage_if: bundle-in/decoded-out bus of format_decode_stage; master drives bundle/enable/stall, slave drives ready and decoded lanes
interface format_decode_stage_if #(
  parameter int lanes = 2,
  parameter int addressWidth = 64,
  parameter int instructionWidth = 32,
  parameter int PidSize = 20,
  parameter int TidSize = 16,
  parameter int instructionCounterWidth = 64,
  parameter int formatWidth = 4,
  parameter int statWidth = 32
);
  logic                                 enable_i;
  logic                                 stall_i;
  logic [lanes-1:0]                     instructionValid_i;
  logic [lanes*instructionWidth-1:0]    instruction_i;
  logic [addressWidth-1:0]              instructionAddress_i;
  logic [PidSize-1:0]                   instructionPid_i;
  logic [TidSize-1:0]                   instructionTid_i;
  logic [instructionCounterWidth-1:0]   instructionMajId_i;
  logic                                 ready_o;
  logic [lanes-1:0]                     valid_o;
  logic [lanes*instructionWidth-1:0]    instruction_o;
  logic [lanes*formatWidth-1:0]         format_o;
  logic [lanes*addressWidth-1:0]        address_o;
  logic [lanes*instructionCounterWidth-1:0] majId_o;
  logic [PidSize-1:0]                   pid_o;
  logic [TidSize-1:0]                   tid_o;
  logic                                 illegal_o;
  logic [2:0]                           illegalLane_o;
  logic [statWidth-1:0]                 decodedCount_o;
  modport master (
    output enable_i, stall_i, instructionValid_i, instruction_i, instructionAddress_i,
           instructionPid_i, instructionTid_i, instructionMajId_i,
    input  ready_o, valid_o, instruction_o, format_o, address_o, majId_o, pid_o, tid_o,
           illegal_o, illegalLane_o, decodedCount_o
  );
  modport slave (
    input  enable_i, stall_i, instructionValid_i, instruction_i, instructionAddress_i,
           instructionPid_i, instructionTid_i, instructionMajId_i,
    output ready_o, valid_o, instruction_o, format_o, address_o, majId_o, pid_o, tid_o,
           illegal_o, illegalLane_o, decodedCount_o
  );
endinterface

// File: rtl/format_decode_stage.sv
// format_decode_stage: per-lane primary-opcode format decode with stall hold, illegal-lane kill and delivered-lane count; ports clock_i, reset_n_i (async low), bus (slave modport)
module format_decode_stage #(
  parameter int lanes = 2,
  parameter int addressWidth = 64,
  parameter int instructionWidth = 32,
  parameter int PidSize = 20,
  parameter int TidSize = 16,
  parameter int instructionCounterWidth = 64,
  parameter int opcodeSize = 6,
  parameter int formatWidth = 4,
  parameter int statWidth = 32
) (
  input logic clock_i,
  input logic reset_n_i,
  format_decode_stage_if.slave bus
);
  localparam int IW = instructionWidth;
  localparam int AW = addressWidth;
  localparam int CW = instructionCounterWidth;
  localparam int FW = formatWidth;
  logic [lanes-1:0]      valid_q, valid_d;
  logic [lanes*IW-1:0]   instr_q;
  logic [lanes*FW-1:0]   fmt_q, fmt_d;
  logic [lanes*AW-1:0]   addr_q, addr_d;
  logic [lanes*CW-1:0]   majid_q, majid_d;
  logic [PidSize-1:0]    pid_q;
  logic [TidSize-1:0]    tid_q;
  logic                  illegal_q, illegal_d;
  logic [2:0]            ill_lane_q, ill_lane_d;
  logic [statWidth-1:0]  count_q, add_d;
  logic                  run;
  logic [5:0]            op;
  logic                  ready, accept;
  function automatic logic [3:0] fmt_of(input logic [5:0] o);
    case (o) inside
      6'd18: return 4'd1;
      6'd16: return 4'd2;
      6'd19: return 4'd3;
      6'd17: return 4'd4;
      6'd2, 6'd3, 6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29], [6'd32:6'd55]: return 4'd5;
      6'd57, 6'd58, 6'd61, 6'd62: return 4'd6;
      6'd56: return 4'd7;
      6'd31: return 4'd8;
      6'd4: return 4'd9;
      6'd20, 6'd21, 6'd23: return 4'd10;
      6'd30: return 4'd11;
      6'd59: return 4'd12;
      6'd63: return 4'd13;
      6'd60: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction
  assign ready  = !(|valid_q) || !bus.stall_i;
  assign accept = bus.enable_i && ready && bus.instructionValid_i[0];
  always_comb begin
    run = 1'b1;
    op = '0;
    valid_d = '0;
    fmt_d = '0;
    addr_d = '0;
    majid_d = '0;
    illegal_d = 1'b0;
    ill_lane_d = '0;
    add_d = '0;
    for (int k = 0; k < lanes; k++) begin
      op = 6'(bus.instruction_i[k*IW + IW - opcodeSize +: opcodeSize]);
      fmt_d[k*FW +: FW] = FW'(fmt_of(op));
      addr_d[k*AW +: AW] = bus.instructionAddress_i + AW'(4 * k);
      majid_d[k*CW +: CW] = bus.instructionMajId_i + CW'(k);
      run = run & bus.instructionValid_i[k];
      valid_d[k] = run & !illegal_d;
      if (valid_d[k] && fmt_d[k*FW +: FW] == '0) begin
        illegal_d = 1'b1;
        ill_lane_d = 3'(k);
      end
      add_d = add_d + statWidth'(valid_d[k]);
    end
  end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      valid_q <= '0;
      instr_q <= '0;
      fmt_q <= '0;
      addr_q <= '0;
      majid_q <= '0;
      pid_q <= '0;
      tid_q <= '0;
      illegal_q <= 1'b0;
      ill_lane_q <= '0;
      count_q <= '0;
    end else if (accept) begin
      valid_q <= valid_d;
      instr_q <= bus.instruction_i;
      fmt_q <= fmt_d;
      addr_q <= addr_d;
      majid_q <= majid_d;
      pid_q <= bus.instructionPid_i;
      tid_q <= bus.instructionTid_i;
      illegal_q <= illegal_d;
      ill_lane_q <= ill_lane_d;
      count_q <= count_q + add_d;
    end else if (ready) begin
      valid_q <= '0;
    end
  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.instruction_o = instr_q;
  assign bus.format_o = fmt_q;
  assign bus.address_o = addr_q;
  assign bus.majId_o = majid_q;
  assign bus.pid_o = pid_q;
  assign bus.tid_o = tid_q;
  assign bus.illegal_o = illegal_q;
  assign bus.illegalLane_o = ill_lane_q;
  assign bus.decodedCount_o = count_q;
endmodule

// File: tb/tb_format_decode_stage.sv
// tb_format_decode_stage: directed-vector bench for format_decode_stage (lanes=2, statWidth=4)
module tb_format_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vec = 0;
  int err = 0;
  logic [3:0] exp_cnt = '0;
  format_decode_stage_if #(.lanes(2), .statWidth(4)) bus();
  format_decode_stage #(.lanes(2), .statWidth(4)) dut (.clock_i(clk), .reset_n_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [63:0] ins(input logic [5:0] o1, input logic [5:0] o0);
    return {o1, 26'h1555555, o0, 26'h2aaaaaa};
  endfunction
  task automatic drive(input logic en, input logic st, input logic [1:0] v, input logic [5:0] o0,
                       input logic [5:0] o1, input logic [63:0] a, input logic [63:0] m);
    @(negedge clk);
    bus.enable_i = en;
    bus.stall_i = st;
    bus.instructionValid_i = v;
    bus.instruction_i = ins(o1, o0);
    bus.instructionAddress_i = a;
    bus.instructionMajId_i = m;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    bus.enable_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.instructionValid_i = '0;
    bus.instruction_i = '0;
    bus.instructionAddress_i = '0;
    bus.instructionPid_i = '0;
    bus.instructionTid_i = '0;
    bus.instructionMajId_i = '0;
    #1 rst_n = 1'b0;
    #2;
    vec++; if (bus.valid_o !== 2'b00) begin err++; $display("FAIL rst_valid got=%b want=00", bus.valid_o); end
    vec++; if (bus.decodedCount_o !== 4'd0) begin err++; $display("FAIL rst_count got=%0d want=0", bus.decodedCount_o); end
    vec++; if (bus.illegal_o !== 1'b0 || bus.illegalLane_o !== 3'd0) begin err++; $display("FAIL rst_illegal got=%b/%0d want=0/0", bus.illegal_o, bus.illegalLane_o); end
    vec++; if (bus.address_o !== 128'd0 || bus.format_o !== 8'd0 || bus.instruction_o !== 64'd0 || bus.majId_o !== 128'd0) begin err++; $display("FAIL rst_data got addr=%h fmt=%h want zero", bus.address_o, bus.format_o); end
    vec++; if (bus.ready_o !== 1'b1) begin err++; $display("FAIL rst_ready got=%b want=1", bus.ready_o); end
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = '0;
  endtask
  task automatic test_basic;
    bus.instructionPid_i = 20'hABCDE;
    bus.instructionTid_i = 16'h1234;
    drive(1, 0, 2'b11, 6'd18, 6'd34, 64'h1000, 64'd7);
    exp_cnt += 4'd2;
    vec++; if (bus.valid_o !== 2'b11) begin err++; $display("FAIL basic_valid got=%b want=11", bus.valid_o); end
    vec++; if (bus.format_o !== 8'h51) begin err++; $display("FAIL basic_format got=%h want=51", bus.format_o); end
    vec++; if (bus.address_o !== {64'h1004, 64'h1000}) begin err++; $display("FAIL basic_addr got=%h want=1004/1000", bus.address_o); end
    vec++; if (bus.majId_o !== {64'd8, 64'd7}) begin err++; $display("FAIL basic_majid got=%h want=8/7", bus.majId_o); end
    vec++; if (bus.instruction_o !== ins(6'd34, 6'd18)) begin err++; $display("FAIL basic_instr got=%h want=%h", bus.instruction_o, ins(6'd34, 6'd18)); end
    vec++; if (bus.pid_o !== 20'hABCDE || bus.tid_o !== 16'h1234) begin err++; $display("FAIL basic_pidtid got=%h/%h want=abcde/1234", bus.pid_o, bus.tid_o); end
    vec++; if (bus.illegal_o !== 1'b0 || bus.illegalLane_o !== 3'd0) begin err++; $display("FAIL basic_illegal got=%b/%0d want=0/0", bus.illegal_o, bus.illegalLane_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL basic_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
    drive(1, 0, 2'b00, 6'd63, 6'd63, 64'h5000, 64'd0);
    vec++; if (bus.valid_o !== 2'b00) begin err++; $display("FAIL idle_valid got=%b want=00", bus.valid_o); end
    vec++; if (bus.format_o !== 8'h51 || bus.address_o !== {64'h1004, 64'h1000}) begin err++; $display("FAIL idle_hold got fmt=%h addr=%h want 51/1004,1000", bus.format_o, bus.address_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL idle_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
  endtask
  task automatic test_illegal;
    drive(1, 0, 2'b11, 6'd0, 6'd31, 64'h2000, 64'd1);
    exp_cnt += 4'd1;
    vec++; if (bus.valid_o !== 2'b01) begin err++; $display("FAIL ill0_valid got=%b want=01", bus.valid_o); end
    vec++; if (bus.format_o[3:0] !== 4'd0) begin err++; $display("FAIL ill0_format got=%h want=0", bus.format_o[3:0]); end
    vec++; if (bus.illegal_o !== 1'b1 || bus.illegalLane_o !== 3'd0) begin err++; $display("FAIL ill0_flag got=%b/%0d want=1/0", bus.illegal_o, bus.illegalLane_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL ill0_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
    drive(1, 0, 2'b11, 6'd59, 6'd1, 64'h2100, 64'd2);
    exp_cnt += 4'd2;
    vec++; if (bus.valid_o !== 2'b11 || bus.format_o !== 8'h0C) begin err++; $display("FAIL ill1_lanes got=%b/%h want=11/0c", bus.valid_o, bus.format_o); end
    vec++; if (bus.illegal_o !== 1'b1 || bus.illegalLane_o !== 3'd1) begin err++; $display("FAIL ill1_flag got=%b/%0d want=1/1", bus.illegal_o, bus.illegalLane_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL ill1_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
  endtask
  task automatic test_noncontig;
    drive(1, 0, 2'b01, 6'd63, 6'd60, 64'h2200, 64'd3);
    exp_cnt += 4'd1;
    vec++; if (bus.valid_o !== 2'b01 || bus.format_o[3:0] !== 4'd13) begin err++; $display("FAIL one_lane got=%b/%h want=01/d", bus.valid_o, bus.format_o[3:0]); end
    vec++; if (bus.illegal_o !== 1'b0 || bus.illegalLane_o !== 3'd0) begin err++; $display("FAIL one_illegal got=%b/%0d want=0/0", bus.illegal_o, bus.illegalLane_o); end
    drive(1, 0, 2'b10, 6'd18, 6'd18, 64'h2300, 64'd4);
    vec++; if (bus.valid_o !== 2'b00) begin err++; $display("FAIL gap_valid got=%b want=00", bus.valid_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL gap_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
  endtask
  task automatic test_stall;
    drive(1, 0, 2'b11, 6'd4, 6'd56, 64'h2000, 64'd100);
    exp_cnt += 4'd2;
    vec++; if (bus.valid_o !== 2'b11 || bus.format_o !== 8'h79) begin err++; $display("FAIL stall_load got=%b/%h want=11/79", bus.valid_o, bus.format_o); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b11, 6'd20, 6'd57, 64'h3000, 64'd200);
      vec++; if (bus.valid_o !== 2'b11 || bus.format_o !== 8'h79) begin err++; $display("FAIL stall_hold%0d got=%b/%h want=11/79", i, bus.valid_o, bus.format_o); end
      vec++; if (bus.address_o !== {64'h2004, 64'h2000} || bus.majId_o !== {64'd101, 64'd100}) begin err++; $display("FAIL stall_data%0d got=%h/%h", i, bus.address_o, bus.majId_o); end
      vec++; if (bus.ready_o !== 1'b0) begin err++; $display("FAIL stall_ready%0d got=%b want=0", i, bus.ready_o); end
      vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL stall_count%0d got=%0d want=%0d", i, bus.decodedCount_o, exp_cnt); end
    end
    drive(1, 0, 2'b11, 6'd20, 6'd57, 64'h3000, 64'd200);
    exp_cnt += 4'd2;
    vec++; if (bus.valid_o !== 2'b11 || bus.format_o !== 8'h6A) begin err++; $display("FAIL release_load got=%b/%h want=11/6a", bus.valid_o, bus.format_o); end
    vec++; if (bus.address_o !== {64'h3004, 64'h3000}) begin err++; $display("FAIL release_addr got=%h want=3004/3000", bus.address_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL release_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
  endtask
  task automatic test_enable;
    drive(0, 1, 2'b11, 6'd2, 6'd2, 64'h4000, 64'd9);
    vec++; if (bus.valid_o !== 2'b11 || bus.format_o !== 8'h6A || bus.ready_o !== 1'b0) begin err++; $display("FAIL en_hold got=%b/%h/%b want=11/6a/0", bus.valid_o, bus.format_o, bus.ready_o); end
    drive(0, 0, 2'b11, 6'd2, 6'd2, 64'h4000, 64'd9);
    vec++; if (bus.valid_o !== 2'b00 || bus.format_o !== 8'h6A) begin err++; $display("FAIL en_off got=%b/%h want=00/6a", bus.valid_o, bus.format_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL en_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
  endtask
  task automatic test_wrap;
    drive(1, 0, 2'b11, 6'd2, 6'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_cnt += 4'd2;
    vec++; if (bus.address_o !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFC}) begin err++; $display("FAIL addr_wrap got=%h", bus.address_o); end
    vec++; if (bus.majId_o !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}) begin err++; $display("FAIL majid_wrap got=%h", bus.majId_o); end
    vec++; if (bus.format_o !== 8'h55 || bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL wrap_step1 got=%h/%0d want=55/%0d", bus.format_o, bus.decodedCount_o, exp_cnt); end
    drive(1, 0, 2'b11, 6'd7, 6'd8, 64'h10, 64'd0);
    exp_cnt += 4'd2;
    drive(1, 0, 2'b01, 6'd10, 6'd10, 64'h20, 64'd0);
    exp_cnt += 4'd1;
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL wrap_pre got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
    drive(1, 0, 2'b11, 6'd16, 6'd17, 64'h30, 64'd0);
    exp_cnt += 4'd2;
    vec++; if (bus.decodedCount_o !== 4'd1 || exp_cnt !== 4'd1) begin err++; $display("FAIL wrap_count got=%0d want=1", bus.decodedCount_o); end
    vec++; if (bus.format_o !== 8'h42) begin err++; $display("FAIL wrap_format got=%h want=42", bus.format_o); end
  endtask
  task automatic test_reset_stall;
    drive(1, 0, 2'b11, 6'd24, 6'd29, 64'h4000, 64'd5);
    drive(1, 1, 2'b11, 6'd18, 6'd18, 64'h5000, 64'd6);
    vec++; if (bus.valid_o !== 2'b11 || bus.address_o !== {64'h4004, 64'h4000}) begin err++; $display("FAIL prerst_hold got=%b/%h", bus.valid_o, bus.address_o); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.valid_o !== 2'b00 || bus.decodedCount_o !== 4'd0) begin err++; $display("FAIL async_rst got=%b/%0d want=00/0", bus.valid_o, bus.decodedCount_o); end
    vec++; if (bus.address_o !== 128'd0 || bus.format_o !== 8'd0 || bus.illegal_o !== 1'b0) begin err++; $display("FAIL async_rst_data got=%h/%h/%b want zero", bus.address_o, bus.format_o, bus.illegal_o); end
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable_i = 1'b1;
    bus.stall_i = 1'b0;
    bus.instructionValid_i = 2'b11;
    bus.instruction_i = ins(6'd34, 6'd18);
    bus.instructionAddress_i = 64'h1000;
    bus.instructionMajId_i = 64'd7;
    @(posedge clk);
    #1;
    exp_cnt += 4'd2;
    vec++; if (bus.valid_o !== 2'b11 || bus.format_o !== 8'h51) begin err++; $display("FAIL first_edge got=%b/%h want=11/51", bus.valid_o, bus.format_o); end
    vec++; if (bus.decodedCount_o !== exp_cnt) begin err++; $display("FAIL first_count got=%0d want=%0d", bus.decodedCount_o, exp_cnt); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_noncontig();
    test_stall();
    test_enable();
    test_wrap();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
